pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the five-stage core. Prioritises per-stage stall requests into the
//  stall[5:0] bus consumed by the PC register and the stage registers. Arbitrates the PC redirect
//  sources (EX-resolved branch vs IF-stage prediction) into br/br_addr and pr/pr_addr. Holds any
//  redirect that arrives while the PC is stalled until the PC can accept it. Drives the
//  IF/ID and ID/EX flush strobes on mispredict.
// PARAMETERS
//  AW        32  address width of PC / redirect targets
//  CNT_W     32  width of performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk            in   1     rising-edge clock, single domain
//  rst            in   1     reset, synchronous, active-low (0 = reset)
//  req_if         in   1     IF stall request (icache miss)
//  req_id         in   1     ID stall request (load-use hazard)
//  req_ex         in   1     EX stall request (multi-cycle mul/div busy)
//  req_mem        in   1     MEM stall request (dcache miss)
//  ex_redir       in   1     EX resolved a mispredicted branch/jump this cycle
//  ex_target      in   AW    correct target for ex_redir
//  if_pred        in   1     IF predictor says taken
//  if_pred_target in   AW    predicted target
//  stall          out  6     [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB hold
//  flush          out  2     [0]=IF/ID bubble, [1]=ID/EX bubble
//  br             out  1     redirect PC to br_addr
//  br_addr        out  AW    redirect target
//  pr             out  1     load PC with pr_addr
//  pr_addr        out  AW    prediction target
//  redir_pending  out  1     a redirect is held, waiting for stall[0] to drop
// BEHAVIOUR
//  - Stall priority, highest wins: req_mem->6'b011111, req_ex->6'b001111, req_id->6'b000111,
//    req_if->6'b000011, none->6'b000000. Combinational, same cycle. WB is never stalled.
//  - FSM, 2 states: RUN, PEND. Registers: state, pend_addr[AW-1:0].
//    RUN:  ex_redir & !stall[0] -> br=1, br_addr=ex_target, flush=2'b11, stay RUN.
//          ex_redir &  stall[0] -> capture pend_addr<=ex_target, go PEND; br=0, flush=0.
//    PEND: redir_pending=1. When stall[0]==0 -> br=1, br_addr=pend_addr, flush=2'b11, go RUN.
//          A new ex_redir in PEND overwrites pend_addr (youngest EX result wins), stays PEND
//          unless stall[0]==0, in which case ex_target is used directly and state -> RUN.
//  - Prediction: pr=if_pred & !stall[0] & !br & (state==RUN); pr_addr=if_pred_target.
//    Redirect always beats prediction in the same cycle.
//  - flush asserted only in the cycle br is asserted; never together with stall[0].
//  - Latency: all outputs combinational from inputs + registered state; PEND entry/exit takes
//    effect on the following posedge.
//  - Reset (rst==0 at posedge): state<=RUN, pend_addr<=0. While rst==0 all outputs forced 0
//    (stall=0, flush=0, br=0, br_addr=0, pr=0, pr_addr=0, redir_pending=0). Reset mid-PEND
//    discards the held redirect.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds CNT_W-bit outputs perf_stall_cyc (cycles stall[0]==1),
//    perf_redir (count of br pulses), perf_pend_cyc (cycles in PEND); cleared by reset,
//    wrap modulo 2^CNT_W, no saturation.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 reset: hold rst=0 3 cycles with all reqs=1 -> all outputs 0; release -> stall follows reqs.
//  2 priority: req_id=1,req_mem=1 -> stall=6'b011111; drop req_mem -> 6'b000111 same cycle.
//  3 plain mispredict: ex_redir=1,ex_target=32'h0001_0400, no reqs -> br=1,br_addr=32'h0001_0400,
//    flush=2'b11, pr=0 even with if_pred=1.
//  4 held redirect: req_mem=1 3 cycles, ex_redir=1 target 32'h0001_04C0 in cycle 1 -> br=0,
//    redir_pending=1 cycles 2-3; req_mem=0 cycle 4 -> br=1 br_addr=32'h0001_04C0, flush=2'b11,
//    redir_pending=0 cycle 5.
//  5 overwrite: in PEND apply ex_redir target 32'h0000_0100 then 32'h0000_0200 while stalled
//    -> on release br_addr=32'h0000_0200, single br pulse.
//  6 reset in PEND: rst=0 one cycle -> after release redir_pending=0, no br pulse on unstall;
//    with PIPE_PERF_CNT_EN all counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bus: stage stall requests, redirect sources and the resulting
// stall/flush/redirect controls. The sequencer uses the slave modport and the core side uses master.
interface pipe_ctrl_if #(
  parameter int unsigned AW = 32
);
  logic          req_if;
  logic          req_id;
  logic          req_ex;
  logic          req_mem;
  logic          ex_redir;
  logic [AW-1:0] ex_target;
  logic          if_pred;
  logic [AW-1:0] if_pred_target;
  logic [5:0]    stall;
  logic [1:0]    flush;
  logic          br;
  logic [AW-1:0] br_addr;
  logic          pr;
  logic [AW-1:0] pr_addr;
  logic          redir_pending;

  modport slave (
    input  req_if, req_id, req_ex, req_mem, ex_redir, ex_target, if_pred, if_pred_target,
    output stall, flush, br, br_addr, pr, pr_addr, redir_pending
  );

  modport master (
    output req_if, req_id, req_ex, req_mem, ex_redir, ex_target, if_pred, if_pred_target,
    input  stall, flush, br, br_addr, pr, pr_addr, redir_pending
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stall prioritisation, redirect/prediction arbitration and
// held-redirect FSM. Define PIPE_PERF_CNT_EN to add the performance counter outputs.
module pipe_ctrl #(
  parameter int unsigned AW    = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_redir,
  output logic [CNT_W-1:0] perf_pend_cyc
`endif
);

  typedef enum logic {RUN, PEND} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pend_q, pend_d;
  logic [5:0]    stall_c;
  logic          br_c;
  logic [AW-1:0] br_addr_c;
  logic          pr_c;

  // Zero-width counters would be meaningless; reject at elaboration.
  if (CNT_W == 0) begin : g_cnt_w_invalid
    initial $fatal(1, "CNT_W must be non-zero");
  end

  // Highest requesting stage freezes itself and everything upstream; WB never holds.
  always_comb begin
    stall_c = 6'b000000;
    if (bus.req_mem)     stall_c = 6'b011111;
    else if (bus.req_ex) stall_c = 6'b001111;
    else if (bus.req_id) stall_c = 6'b000111;
    else if (bus.req_if) stall_c = 6'b000011;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A redirect that meets a stalled PC is parked; the youngest EX result always wins.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    br_c      = 1'b0;
    br_addr_c = '0;
    case (state_q)
      RUN: begin
        if (bus.ex_redir) begin
          if (!stall_c[0]) begin
            br_c      = 1'b1;
            br_addr_c = bus.ex_target;
          end else begin
            pend_d  = bus.ex_target;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!stall_c[0]) begin
          br_c      = 1'b1;
          br_addr_c = bus.ex_redir ? bus.ex_target : pend_q;
          state_d   = RUN;
        end else if (bus.ex_redir) begin
          pend_d = bus.ex_target;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pr_c = bus.if_pred & ~stall_c[0] & ~br_c & (state_q == RUN);

  // Every output is held at zero while reset is asserted.
  always_comb begin
    bus.stall         = '0;
    bus.flush         = '0;
    bus.br            = 1'b0;
    bus.br_addr       = '0;
    bus.pr            = 1'b0;
    bus.pr_addr       = '0;
    bus.redir_pending = 1'b0;
    if (rst) begin
      bus.stall         = stall_c;
      bus.flush         = br_c ? 2'b11 : 2'b00;
      bus.br            = br_c;
      bus.br_addr       = br_addr_c;
      bus.pr            = pr_c;
      bus.pr_addr       = bus.if_pred_target;
      bus.redir_pending = (state_q == PEND);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_redir     <= '0;
      perf_pend_cyc  <= '0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + CNT_W'(stall_c[0]);
      perf_redir     <= perf_redir + CNT_W'(br_c);
      perf_pend_cyc  <= perf_pend_cyc + CNT_W'(state_q == PEND);
    end
  end
`endif

endmodule
